// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM encoding, scan-code constants and the frame check.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] KEY_SPACE    = 8'h29;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the PS/2 lines, deglitches ps2_clk and emits a one-cycle falling-edge pulse.
module ps2_sync_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // A new level is accepted only after it has differed from filt_q for FILTER_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_q    <= 1'b1;
      cnt_q     <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_q <= clk_sync[1];
        cnt_q  <= '0;
        fall   <= filt_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_space_decoder.sv
// PS/2 keyboard frame receiver plus make/break decode driving a level for one key.
module ps2_space_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 500,
  parameter logic [7:0]  KEY_CODE       = KEY_SPACE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       button_pressed,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic data_s;

  ps2_sync_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          btn_d;
  logic [7:0]    code_d;
  logic          valid_d;
  logic          err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      parity_q       <= 1'b0;
      timer_q        <= '0;
      brk_q          <= 1'b0;
      ext_q          <= 1'b0;
      button_pressed <= 1'b0;
      code           <= 8'h00;
      code_valid     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      timer_q        <= timer_d;
      brk_q          <= brk_d;
      ext_q          <= ext_d;
      button_pressed <= btn_d;
      code           <= code_d;
      code_valid     <= valid_d;
      frame_err      <= err_d;
    end
  end

  // Frame sequencing, idle timeout and prefix-aware key decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    btn_d     = button_pressed;
    code_d    = code;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q != ST_IDLE) timer_d = timer_q + TW'(1);

    if (fall) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (frame_ok(shift_q, parity_q, data_s)) begin
            valid_d = 1'b1;
            code_d  = shift_q;
            if (shift_q == BREAK_PREFIX) begin
              brk_d = 1'b1;
            end else if (shift_q == EXT_PREFIX) begin
              ext_d = 1'b1;
            end else begin
              if (shift_q == KEY_CODE && !ext_q) btn_d = !brk_q;
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      timer_d = '0;
      err_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_space_decoder.sv
// Scoreboard bench for ps2_space_decoder: bit-banged PS/2 frames against a small key model.
module tb_ps2_space_decoder;

  localparam int unsigned HALF    = 200;
  localparam int unsigned TIMEOUT = 2000;
  localparam logic [7:0]  KEY     = 8'h29;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [7:0] code;
    logic       btn;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       button_pressed;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_btn = 1'b0;
  logic [7:0] m_code = 8'h00;

  ps2_space_decoder #(
    .FILTER_CYCLES  (8),
    .TIMEOUT_CYCLES (TIMEOUT),
    .KEY_CODE       (KEY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .button_pressed (button_pressed),
    .code           (code),
    .code_valid     (code_valid),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Capture every result pulse the DUT produces.
  always @(negedge clk) begin
    if (!rst && (code_valid || frame_err))
      obs_q.push_back('{code_valid, frame_err, code, button_pressed});
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (b == KEY && !m_ext) m_btn = !m_brk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    m_code = b;
    exp_q.push_back('{1'b1, 1'b0, b, m_btn});
  endtask

  task automatic expect_err();
    exp_q.push_back('{1'b0, 1'b1, m_code, m_btn});
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (code !== 8'h00) $display("FAIL reset_code got %h want 00", code); else n_pass++;
    n_checks++; if (button_pressed !== 1'b0) $display("FAIL reset_btn got %b want 0", button_pressed); else n_pass++;
    n_checks++; if (code_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", code_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err); else n_pass++;
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_make();
    ev_t e, o;
    send_frame(KEY, 1'b0, 1'b1); expect_byte(KEY);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL make_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL make_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_typematic();
    ev_t e, o;
    logic [7:0] seq [4];
    seq = '{8'h29, 8'h29, 8'hF0, 8'h29};
    foreach (seq[i]) begin
      send_frame(seq[i], 1'b0, 1'b1);
      expect_byte(seq[i]);
    end
    n_checks++;
    if (obs_q.size() !== 4) $display("FAIL typematic_count got %0d want 4", obs_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL typematic_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_frames();
    ev_t e, o;
    send_frame(KEY, 1'b0, 1'b1); expect_byte(KEY);
    send_frame(KEY, 1'b1, 1'b1); expect_err();
    send_frame(8'hF0, 1'b0, 1'b0); expect_err();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL bad_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL bad_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_extended();
    ev_t e, o;
    logic [7:0] seq [6];
    seq = '{8'hF0, 8'h29, 8'hE0, 8'h29, 8'hE0, 8'hF0};
    foreach (seq[i]) begin
      send_frame(seq[i], 1'b0, 1'b1);
      expect_byte(seq[i]);
    end
    send_frame(8'h29, 1'b0, 1'b1); expect_byte(8'h29);
    send_frame(8'h29, 1'b0, 1'b1); expect_byte(8'h29);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL ext_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL ext_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    ev_t e, o;
    send_frame(8'hF0, 1'b0, 1'b1); expect_byte(8'hF0);
    send_frame(KEY, 1'b0, 1'b1); expect_byte(KEY);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 300) @(negedge clk);
    expect_err();
    send_frame(KEY, 1'b0, 1'b1); expect_byte(KEY);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL timeout_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++; if (obs_q.size() !== 0) $display("FAIL glitch_events got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (code !== m_code) $display("FAIL glitch_code got %h want %h", code, m_code); else n_pass++;
    n_checks++; if (button_pressed !== m_btn) $display("FAIL glitch_btn got %b want %b", button_pressed, m_btn); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_mid_reset();
    ev_t e, o;
    send_frame(8'hF0, 1'b0, 1'b1); expect_byte(8'hF0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (code !== 8'h00) $display("FAIL midrst_code got %h want 00", code); else n_pass++;
    n_checks++; if (button_pressed !== 1'b0) $display("FAIL midrst_btn got %b want 0", button_pressed); else n_pass++;
    n_checks++; if ((code_valid | frame_err) !== 1'b0) $display("FAIL midrst_pulses got %b%b want 00", code_valid, frame_err); else n_pass++;
    rst = 1'b0;
    ps2_data = 1'b1;
    m_brk = 1'b0; m_ext = 1'b0; m_btn = 1'b0; m_code = 8'h00;
    repeat (HALF) @(negedge clk);
    send_frame(KEY, 1'b0, 1'b1); expect_byte(KEY);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL midrst_event got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_make();
    test_typematic();
    test_bad_frames();
    test_extended();
    test_timeout();
    test_glitch();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
